code_lock: RTL and testbench

Two-digit sequential combination lock for the DE1-SoC lab board. The operator sets a BCD digit on SW[3:0] and presses KEY[0] to enter it. The block checks the entered sequence against a two-digit code (default 57), drives an unlock pulse for the LEDs, counts failed attempts and enforces a timed lockout. It sits directly downstream of the switch-match logic, replacing its static compare with a clocked entry sequencer.

---
 rtl/code_lock.sv | 186 ++++++++++++++++++
 tb/tb_code_lock.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/code_lock.sv
// Two-digit sequential combination lock: synchronised key entry, unlock pulse,
// failed-attempt counter and timed lockout (lockout enabled by CODE_LOCK_LOCKOUT_EN).
module code_lock #(
  parameter logic [3:0]  CODE_HI       = 4'd5,
  parameter logic [3:0]  CODE_LO       = 4'd7,
  parameter int unsigned MAX_FAILS     = 3,
  parameter int unsigned UNLOCK_CYCLES = 50_000_000,
  parameter int unsigned LOCK_CYCLES   = 250_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       key_n,
  input  logic [3:0] digit,
  output logic       unlock,
  output logic       locked_out,
  output logic [1:0] fails,
  output logic [3:0] last_digit,
  output logic       expect_lo
);

  localparam int unsigned MAX_CYC = (UNLOCK_CYCLES > LOCK_CYCLES) ? UNLOCK_CYCLES : LOCK_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;
  localparam int unsigned FAIL_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GOT1    = 2'd1,
    ST_OPEN    = 2'd2
`ifdef CODE_LOCK_LOCKOUT_EN
    ,
    ST_LOCKOUT = 2'd3
`endif
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [FAIL_W-1:0]   fails_q, fails_d;
  logic [3:0]          last_q, last_d;
  logic                sync1_q, sync1_d;
  logic                sync2_q, sync2_d;
  logic                sync3_q, sync3_d;
  logic                unlock_q, unlock_d;
  logic                expect_lo_q, expect_lo_d;
  logic                press_c;
  logic                fail_c;
  logic                digit_hi_c;
  logic                digit_lo_c;

  // Synchroniser + edge detect: one pulse per synchronised high->low transition
  assign press_c    = sync3_q & ~sync2_q;
  assign digit_hi_c = (digit == CODE_HI) && (digit <= 4'd9);
  assign digit_lo_c = (digit == CODE_LO) && (digit <= 4'd9);

`ifdef CODE_LOCK_LOCKOUT_EN
  logic locked_out_q, locked_out_d;
`endif

  // State register and all registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      fails_q     <= '0;
      last_q      <= 4'h0;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      sync3_q     <= 1'b1;
      unlock_q    <= 1'b0;
      expect_lo_q <= 1'b0;
`ifdef CODE_LOCK_LOCKOUT_EN
      locked_out_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fails_q     <= fails_d;
      last_q      <= last_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      sync3_q     <= sync3_d;
      unlock_q    <= unlock_d;
      expect_lo_q <= expect_lo_d;
`ifdef CODE_LOCK_LOCKOUT_EN
      locked_out_q <= locked_out_d;
`endif
    end
  end

  // Next-state, timer and counter logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fails_d     = fails_q;
    last_d      = last_q;
    sync1_d     = key_n;
    sync2_d     = sync1_q;
    sync3_d     = sync2_q;
    fail_c      = 1'b0;
    unlock_d    = 1'b0;
    expect_lo_d = 1'b0;
`ifdef CODE_LOCK_LOCKOUT_EN
    locked_out_d = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (press_c) begin
          last_d = digit;
          if (digit_hi_c) begin
            state_d = ST_GOT1;
          end else begin
            fail_c = 1'b1;
          end
        end
      end
      ST_GOT1: begin
        // A repeated first digit is a failure, not a restart
        if (press_c) begin
          last_d = digit;
          if (digit_lo_c) begin
            state_d = ST_OPEN;
            fails_d = '0;
            cnt_d   = CNT_W'(UNLOCK_CYCLES - 1);
          end else begin
            fail_c = 1'b1;
          end
        end
      end
      ST_OPEN: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`ifdef CODE_LOCK_LOCKOUT_EN
      ST_LOCKOUT: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          fails_d = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (fail_c) begin
`ifdef CODE_LOCK_LOCKOUT_EN
      fails_d = fails_q + FAIL_W'(1);
      if ((32'(fails_q) + 32'd1) == MAX_FAILS) begin
        state_d = ST_LOCKOUT;
        cnt_d   = CNT_W'(LOCK_CYCLES - 1);
      end else begin
        state_d = ST_IDLE;
      end
`else
      if (32'(fails_q) < MAX_FAILS) begin
        fails_d = fails_q + FAIL_W'(1);
      end
      state_d = ST_IDLE;
`endif
    end

    // Outputs track the state being entered so they change on the same edge
    unlock_d    = (state_d == ST_OPEN);
    expect_lo_d = (state_d == ST_GOT1);
`ifdef CODE_LOCK_LOCKOUT_EN
    locked_out_d = (state_d == ST_LOCKOUT);
`endif
  end

  assign unlock     = unlock_q;
  assign expect_lo  = expect_lo_q;
  assign fails      = fails_q;
  assign last_digit = last_q;
`ifdef CODE_LOCK_LOCKOUT_EN
  assign locked_out = locked_out_q;
`else
  assign locked_out = 1'b0;
`endif

endmodule

// File: tb/tb_code_lock.sv
// Scoreboard bench for code_lock: a transaction-level lock model predicts the
// outputs after every clock edge; a negedge monitor compares them against the DUT.
module tb_code_lock;

  localparam int unsigned U_CYC  = 4;
  localparam int unsigned L_CYC  = 8;
  localparam int unsigned MAXF   = 3;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       key_n;
  logic [3:0] digit;
  logic       unlock;
  logic       locked_out;
  logic [1:0] fails;
  logic [3:0] last_digit;
  logic       expect_lo;

  int total = 0;
  int bad   = 0;

  logic [8:0] sb_q[$];

  // Model: 0 idle, 1 got first digit, 2 open, 3 lockout
  int         m_st;
  int         m_rem;
  int         m_fails;
  logic [3:0] m_last;
  logic       k1, k2, k3;

  always #5 clk = ~clk;

  code_lock #(
    .CODE_HI(4'd5),
    .CODE_LO(4'd7),
    .MAX_FAILS(MAXF),
    .UNLOCK_CYCLES(U_CYC),
    .LOCK_CYCLES(L_CYC)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .key_n(key_n),
    .digit(digit),
    .unlock(unlock),
    .locked_out(locked_out),
    .fails(fails),
    .last_digit(last_digit),
    .expect_lo(expect_lo)
  );

  function automatic logic [8:0] dut_out();
    return {unlock, locked_out, fails, last_digit, expect_lo};
  endfunction

  function automatic logic [8:0] model_out();
    logic o_un, o_lk, o_lo;
    o_un = (m_st == 2);
    o_lk = (m_st == 3);
    o_lo = (m_st == 1);
    return {o_un, o_lk, 2'(m_fails), m_last, o_lo};
  endfunction

  task automatic model_reset();
    m_st = 0; m_rem = 0; m_fails = 0; m_last = 4'h0;
    k1 = 1'b1; k2 = 1'b1; k3 = 1'b1;
  endtask

  task automatic model_fail();
`ifdef CODE_LOCK_LOCKOUT_EN
    m_fails = m_fails + 1;
    if (m_fails == int'(MAXF)) begin
      m_st  = 3;
      m_rem = L_CYC;
    end else begin
      m_st = 0;
    end
`else
    if (m_fails < int'(MAXF)) m_fails = m_fails + 1;
    m_st = 0;
`endif
  endtask

  // One clock edge: k is key_n sampled at this edge, d is the digit in the preceding cycle
  task automatic model_edge(input logic k, input logic [3:0] d);
    logic press;
    press = (k2 == 1'b0) && (k3 == 1'b1);
    k3 = k2; k2 = k1; k1 = k;
    if (m_st == 0 || m_st == 1) begin
      if (press) begin
        m_last = d;
        if (m_st == 0 && d == 4'd5) begin
          m_st = 1;
        end else if (m_st == 1 && d == 4'd7) begin
          m_st = 2; m_rem = U_CYC; m_fails = 0;
        end else begin
          model_fail();
        end
      end
    end else begin
      m_rem = m_rem - 1;
      if (m_rem == 0) begin
        if (m_st == 3) m_fails = 0;
        m_st = 0;
      end
    end
  endtask

  task automatic chk(input string name, input logic [8:0] got, input logic [8:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got=%h want=%h (unlock,locked_out,fails,last_digit,expect_lo)", name, got, exp);
    end
  endtask

  task automatic step(input logic k, input logic [3:0] d);
    key_n = k;
    digit = d;
    @(posedge clk);
    model_edge(k, d);
    sb_q.push_back(model_out());
    #1;
  endtask

  task automatic press(input logic [3:0] d);
    step(1'b1, d);
    repeat (3) step(1'b0, d);
    step(1'b1, d);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b1, 4'd0);
  endtask

  task automatic async_reset(input string name);
    @(negedge clk);
    #2;
    chk({name, "_pre"}, dut_out(), model_out());
    reset_n = 1'b0;
    #1;
    chk({name, "_async"}, dut_out(), 9'h000);
    @(posedge clk);
    #1;
    chk({name, "_held"}, dut_out(), 9'h000);
    key_n   = 1'b1;
    reset_n = 1'b1;
    model_reset();
  endtask

  // Monitor: every cycle the DUT presents a fresh output word, checked against the queue head
  always @(negedge clk) begin
    if (reset_n === 1'b1 && sb_q.size() > 0) begin
      logic [8:0] exp_v;
      exp_v = sb_q.pop_front();
      total = total + 1;
      if (dut_out() !== exp_v) begin
        bad = bad + 1;
        $display("FAIL outputs @%0t: got=%h want=%h", $time, dut_out(), exp_v);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    key_n   = 1'b1;
    digit   = 4'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_values", dut_out(), 9'h000);
    reset_n = 1'b1;

    // Correct code
    press(4'd5);
    press(4'd7);
    idle(8);

    // Repeated first digit fails, then a lone second digit fails from idle
    press(4'd5);
    press(4'd5);
    press(4'd7);
    idle(3);

    // Clear the fail count with a good entry
    press(4'd5);
    press(4'd7);
    idle(6);

    // Three wrong digits, then presses during lockout (ignored when enabled)
    press(4'd3);
    press(4'd12);
    press(4'd9);
    press(4'd5);
    press(4'd7);
    idle(12);

    // Held key yields a single press
    step(1'b1, 4'd5);
    repeat (20) step(1'b0, 4'd5);
    step(1'b1, 4'd5);
    idle(2);

    // Enter OPEN, then abort with reset
    press(4'd7);
    async_reset("rst_open");
    idle(3);

`ifdef CODE_LOCK_LOCKOUT_EN
    press(4'd1);
    press(4'd2);
    press(4'd3);
    async_reset("rst_lockout");
    idle(3);
`else
    for (int i = 0; i < 5; i++) press(4'(i));
    press(4'd5);
    press(4'd7);
    idle(6);
`endif

    // Randomised key activity biased towards the code digits
    for (int s = 0; s < 300; s++) begin
      logic       k;
      logic [3:0] d;
      int         r;
      k = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 9);
      if (r < 4)      d = 4'd5;
      else if (r < 7) d = 4'd7;
      else            d = 4'($urandom_range(0, 15));
      repeat ($urandom_range(1, 6)) step(k, d);
    end

    idle(20);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 9'(sb_q.size()), 9'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
